// File: rtl/spongent_drv_pkg.sv
// rtl/spongent_drv_pkg.sv - shared state type and block-geometry helpers for the Spongent message driver
package spongent_drv_pkg;

  typedef enum logic [2:0] {
    RST_CORE,
    COLLECT,
    SEND,
    WAIT_IDLE,
    FINAL,
    DONE
  } drv_state_t;

  function automatic int bytes_per_block(input int rate);
    return rate / 8;
  endfunction

  // A one-byte block still needs a one-bit counter to keep the port widths legal.
  function automatic int count_width(input int rate);
    return (rate / 8 > 1) ? $clog2(rate / 8) : 1;
  endfunction

endpackage

// File: rtl/spongent_byte_packer.sv
// rtl/spongent_byte_packer.sv - packs message bytes MSB-first into R-bit core blocks, zero-filling a short final block
module spongent_byte_packer
  import spongent_drv_pkg::*;
#(
  parameter int R = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic [7:0]   data,
  input  logic         last,
  output logic [R-1:0] block,
  output logic         block_done,
  output logic         len_err
);

  localparam int BYTES_PER_BLOCK = bytes_per_block(R);
  localparam int CW = count_width(R);

  logic [CW-1:0] count;
  logic          at_end;

  assign at_end     = (count == CW'(BYTES_PER_BLOCK - 1));
  assign block_done = shift && (at_end || last);

  always_ff @(posedge clk) begin
    if (rst) begin
      block   <= '0;
      count   <= '0;
      len_err <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      len_err <= 1'b0;
    end else if (shift) begin
      // The first byte wipes the previous block, so a short tail is already zero-filled.
      if (count == '0) begin
        block <= R'(data) << (R - 8);
      end else begin
        block[R-1-8*int'(count) -: 8] <= data;
      end
      count <= (at_end || last) ? '0 : count + 1'b1;
      if (last && !at_end) begin
        len_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spongent_msg_driver.sv
// rtl/spongent_msg_driver.sv - host-side driver for the iterative Spongent core; SPONGENT_DRV_TIMEOUT_EN adds a per-phase watchdog
module spongent_msg_driver
  import spongent_drv_pkg::*;
#(
  parameter int N = 256,
  parameter int R = 16
`ifdef SPONGENT_DRV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         core_rst,
  output logic [R-1:0] core_data,
  output logic         core_data_ready,
  output logic         core_start_hash,
  input  logic         core_busy,
  input  logic         core_end_hash,
  input  logic [N-1:0] core_digest,
  output logic [N-1:0] digest,
  output logic         digest_valid,
  input  logic         digest_ack,
  output logic         len_err
`ifdef SPONGENT_DRV_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  drv_state_t state, state_next;
  logic       is_last;
  logic       pack_done;
  logic       hash_done;
  logic       wd_expired;

  assign hash_done = (state == FINAL) && core_end_hash && !core_busy;

  spongent_byte_packer #(.R(R)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == RST_CORE),
    .shift     (s_valid && s_ready),
    .data      (s_data),
    .last      (s_last),
    .block     (core_data),
    .block_done(pack_done),
    .len_err   (len_err)
  );

`ifdef SPONGENT_DRV_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;

  // The counter restarts on every state change, so it measures time spent in the current wait phase.
  assign wd_expired = (state == SEND || state == WAIT_IDLE || state == FINAL) &&
                      (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    s_ready         = 1'b0;
    core_rst        = 1'b0;
    core_data_ready = 1'b0;
    core_start_hash = 1'b0;
    digest_valid    = 1'b0;
    case (state)
      RST_CORE: begin
        core_rst   = 1'b1;
        state_next = COLLECT;
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (pack_done) state_next = SEND;
      end
      SEND: begin
        core_data_ready = 1'b1;
        if (core_busy) state_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!core_busy) state_next = is_last ? FINAL : COLLECT;
      end
      FINAL: begin
        core_start_hash = 1'b1;
        if (hash_done) state_next = DONE;
      end
      DONE: begin
        digest_valid = 1'b1;
        if (digest_ack) state_next = RST_CORE;
      end
      default: state_next = RST_CORE;
    endcase
    if (wd_expired) state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_CORE;
      is_last <= 1'b0;
      digest  <= '0;
`ifdef SPONGENT_DRV_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == RST_CORE) is_last <= 1'b0;
      else if (pack_done)    is_last <= s_last;
      if (hash_done) digest <= core_digest;
`ifdef SPONGENT_DRV_TIMEOUT_EN
      wd_cnt <= (state_next != state) ? '0 : wd_cnt + 1'b1;
      if (state == RST_CORE) timeout_err <= 1'b0;
      if (wd_expired) begin
        digest      <= '0;
        timeout_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spongent_msg_driver.sv
// tb/tb_spongent_msg_driver.sv - self-checking bench: vector table, corner sequences and random messages against a core model
module tb_spongent_msg_driver;

  localparam int N   = 256;
  localparam int R   = 16;
  localparam int BPB = R / 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         core_rst;
  logic [R-1:0] core_data;
  logic         core_data_ready;
  logic         core_start_hash;
  logic         core_busy;
  logic         core_end_hash;
  logic [N-1:0] core_digest;
  logic [N-1:0] digest;
  logic         digest_valid;
  logic         digest_ack;
  logic         len_err;

  spongent_msg_driver #(.N(N), .R(R)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .core_rst       (core_rst),
    .core_data      (core_data),
    .core_data_ready(core_data_ready),
    .core_start_hash(core_start_hash),
    .core_busy      (core_busy),
    .core_end_hash  (core_end_hash),
    .core_digest    (core_digest),
    .digest         (digest),
    .digest_valid   (digest_valid),
    .digest_ack     (digest_ack),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural core: records each block it accepts, stalls a random time, returns a random digest.
  logic [R-1:0] got_q[$];
  logic [N-1:0] exp_digest;
  logic [R-1:0] seen_data;
  bit           seen_dr;
  bit           hold_busy;
  int           phase, perm_left, dly, viol, rst_run, last_rst_len;

  initial begin : core_model
    core_busy = 1'b0; core_end_hash = 1'b0; core_digest = '0;
    phase = 0; perm_left = 0; dly = 0; viol = 0; rst_run = 0; last_rst_len = 0;
    hold_busy = 1'b0; seen_dr = 1'b0; seen_data = '0;
    forever begin
      @(negedge clk);
      if (core_data_ready && core_start_hash) viol++;
      if (phase != 0 && core_data_ready) viol++;
      if (phase == 1 && core_start_hash) viol++;
      if (core_data_ready) begin
        if (seen_dr && core_data !== seen_data) viol++;
        seen_dr = 1'b1; seen_data = core_data;
      end else begin
        seen_dr = 1'b0;
      end
      if (core_rst) rst_run++;
      else if (rst_run > 0) begin last_rst_len = rst_run; rst_run = 0; end
      if (core_rst) begin
        core_busy = 1'b0; core_end_hash = 1'b0; phase = 0; got_q.delete();
        dly = $urandom_range(0, 3);
      end else begin
        case (phase)
          0: begin
            if (core_data_ready || core_start_hash) begin
              if (dly == 0) begin
                if (core_data_ready) got_q.push_back(core_data);
                core_busy = 1'b1;
                phase = core_data_ready ? 1 : 2;
                perm_left = $urandom_range(1, 5);
                dly = $urandom_range(0, 3);
              end else begin
                dly--;
              end
            end
          end
          1, 2: begin
            if (!hold_busy) begin
              if (perm_left > 0) perm_left--;
              else begin
                core_busy = 1'b0;
                if (phase == 2) begin
                  core_digest = rand_wide(); exp_digest = core_digest;
                  core_end_hash = 1'b1; phase = 3;
                end else begin
                  phase = 0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [7:0]   msg[$];
  logic [R-1:0] exp_q[$];
  bit           exp_lerr;

  // Reference packing: block b is the big-endian concatenation of bytes b*BPB.., zero past the end.
  task automatic build_expected();
    logic [R-1:0] v;
    int nblk;
    exp_q.delete();
    nblk = (msg.size() + BPB - 1) / BPB;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int k = 0; k < BPB; k++) begin
        v = v << 8;
        if (b * BPB + k < msg.size()) v = v | R'(msg[b * BPB + k]);
      end
      exp_q.push_back(v);
    end
    exp_lerr = (msg.size() % BPB) != 0;
  endtask

  task automatic send_bytes(input int gap_pct);
    int cyc;
    viol = 0;
    for (int i = 0; i < msg.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0; s_data = 8'($urandom); @(negedge clk);
      end
      s_valid = 1'b1; s_data = msg[i]; s_last = (i == msg.size() - 1);
      cyc = 0;
      while (!s_ready && cyc < 1000) begin @(negedge clk); cyc++; end
      check($sformatf("s_ready byte%0d", i), N'(s_ready), N'(1));
      if (!s_ready) begin s_valid = 1'b0; s_last = 1'b0; return; end
      @(negedge clk);
      if (i == 0) digest_ack = 1'b0;
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic finish_message(input string tag, input int ack_delay, input bit ack_hold);
    int cyc;
    bit ok;
    logic [N-1:0] d0;
    logic [N-1:0] a;
    cyc = 0;
    while (!digest_valid && cyc < 4000) begin @(negedge clk); cyc++; end
    check({tag, " digest_valid"}, N'(digest_valid), N'(1));
    if (!digest_valid) return;
    check({tag, " nblocks"}, N'(got_q.size()), N'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = '1;
      if (i < got_q.size()) a = N'(got_q[i]);
      check($sformatf("%s block%0d", tag, i), a, N'(exp_q[i]));
    end
    check({tag, " len_err"}, N'(len_err), N'(exp_lerr));
    check({tag, " digest"}, digest, exp_digest);
    check({tag, " handshake_rules"}, N'(viol), N'(0));
    if (ack_delay > 0) begin
      ok = 1'b1; d0 = digest;
      repeat (ack_delay) begin
        @(negedge clk);
        if (digest !== d0 || digest_valid !== 1'b1 || len_err !== exp_lerr) ok = 1'b0;
      end
      check({tag, " hold_stable"}, N'(ok), N'(1));
    end
    digest_ack = 1'b1;
    @(negedge clk);
    check({tag, " valid_drop"}, N'(digest_valid), N'(0));
    check({tag, " core_rst_after_ack"}, N'(core_rst), N'(1));
    if (!ack_hold) digest_ack = 1'b0;
  endtask

  typedef struct packed {
    int          len;
    logic [63:0] bytes;
    logic [63:0] blks;
    int          nblk;
    bit          lerr;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    vec_t v;
    vecs.push_back('{len: 2, bytes: 64'hABCD_0000_0000_0000, blks: 64'hABCD_0000_0000_0000, nblk: 1, lerr: 1'b0});
    vecs.push_back('{len: 5, bytes: 64'h0102_0304_0500_0000, blks: 64'h0102_0304_0500_0000, nblk: 3, lerr: 1'b1});
    vecs.push_back('{len: 1, bytes: 64'h7E00_0000_0000_0000, blks: 64'h7E00_0000_0000_0000, nblk: 1, lerr: 1'b1});
    vecs.push_back('{len: 4, bytes: 64'h1122_3344_0000_0000, blks: 64'h1122_3344_0000_0000, nblk: 2, lerr: 1'b0});
    vecs.push_back('{len: 6, bytes: 64'hFF00_8001_5AA5_0000, blks: 64'hFF00_8001_5AA5_0000, nblk: 3, lerr: 1'b0});

    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; digest_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst core_rst", N'(core_rst), N'(1));
    check("rst s_ready", N'(s_ready), N'(0));
    check("rst core_data_ready", N'(core_data_ready), N'(0));
    check("rst core_start_hash", N'(core_start_hash), N'(0));
    check("rst digest_valid", N'(digest_valid), N'(0));
    check("rst len_err", N'(len_err), N'(0));
    check("rst digest", digest, N'(0));
    check("rst core_data", N'(core_data), N'(0));
    rst = 1'b0;

    for (int t = 0; t < vecs.size(); t++) begin
      v = vecs[t];
      msg.delete();
      for (int i = 0; i < v.len; i++) msg.push_back(v.bytes[63 - 8 * i -: 8]);
      exp_q.delete();
      for (int i = 0; i < v.nblk; i++) exp_q.push_back(v.blks[63 - 16 * i -: 16]);
      exp_lerr = v.lerr;
      send_bytes(0);
      finish_message($sformatf("vec%0d", t), t % 3, 1'b0);
    end

    // Back-to-back: ack stays high across the boundary.
    msg = '{8'h10, 8'h20, 8'h30};
    build_expected(); send_bytes(0); finish_message("b2b_a", 0, 1'b1);
    msg = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    build_expected(); send_bytes(0); finish_message("b2b_b", 0, 1'b0);
    check("b2b core_rst_pulse", N'(last_rst_len), N'(1));

    msg = '{8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h12, 8'h34, 8'h56};
    build_expected(); send_bytes(40); finish_message("gaps_ack50", 50, 1'b0);

    // Reset while the driver waits for the core to go idle.
    msg = '{8'hC3, 8'h3C};
    build_expected();
    hold_busy = 1'b1;
    send_bytes(0);
    cyc = 0;
    while (!(core_busy && !core_data_ready) && cyc < 200) begin @(negedge clk); cyc++; end
    check("wait_idle reached", N'(core_busy && !core_data_ready), N'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst core_rst", N'(core_rst), N'(1));
    check("mid_rst s_ready", N'(s_ready), N'(0));
    check("mid_rst digest_valid", N'(digest_valid), N'(0));
    rst = 1'b0; hold_busy = 1'b0;
    msg = '{8'h5E, 8'hED, 8'h01};
    build_expected(); send_bytes(10); finish_message("after_rst", 2, 1'b0);

    for (int m = 0; m < 15; m++) begin
      int len;
      len = $urandom_range(1, 10);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      build_expected();
      send_bytes($urandom_range(0, 50));
      finish_message($sformatf("rnd%0d", m), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    digest_ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spongent_msg_driver.md
Name: spongent_msg_driver

Overview:
- Host-side driver for the iterative Spongent hash core. It is the initiator end of the core's data_ready / busy / start_hash / end_hash handshake.
- Accepts a message as a byte stream (valid/ready with last flag) and packs bytes into r-bit blocks.
- Sequences the blocks into the core, then triggers finalisation.
- Captures the N-bit digest, holds it until acknowledged, and resets the core for the next message.

Parameters:
- N, 256, digest width in bits; must equal the core's N.
- r, 16, core rate in bits; 8 or 16 only.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait phase. Used only with SPONGENT_DRV_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_data  in  8  message byte
- s_valid  in  1  byte valid
- s_last  in  1  final byte of message
- s_ready  out  1  driver accepts byte
- core_rst  out  1  reset to hash core
- core_data  out  r  block to core data_input
- core_data_ready  out  1  to core data_ready
- core_start_hash  out  1  to core start_hash
- core_busy  in  1  from core busy
- core_end_hash  in  1  from core end_hash
- core_digest  in  N  from core digest
- digest  out  N  captured digest
- digest_valid  out  1  digest held valid
- digest_ack  in  1  consumer accepts digest
- len_err  out  1  final block was partial and zero-filled; qualified by digest_valid

Behaviour:
- Reset values:
  - state = RST_CORE; core_rst=1.
  - s_ready, core_data_ready, core_start_hash, digest_valid, len_err = 0.
  - digest and core_data = 0; byte count = 0.
- FSM states: RST_CORE, COLLECT, SEND, WAIT_IDLE, FINAL, DONE.
- RST_CORE:
  - core_rst=1 for exactly one cycle, then go to COLLECT.
  - Clears byte count and the last flag.
- COLLECT:
  - s_ready=1.
  - Each s_valid&&s_ready byte shifts into core_data MSB-first: the first byte lands in core_data[r-1:r-8].
  - Count wraps at r/8.
  - On block full or s_last: s_ready drops the same cycle, go to SEND, latch is_last=s_last.
  - s_last with a partial block: remaining bytes zero-filled, len_err=1.
- SEND:
  - core_data_ready=1 and core_data stable.
  - Stay until core_busy=1 is sampled; core_data_ready drops that same edge, then go to WAIT_IDLE.
  - core_data stays unchanged until the next COLLECT write. The core loads its permutation input one cycle after sampling data_ready.
- WAIT_IDLE:
  - Wait for core_busy=0.
  - Then go to FINAL if is_last, else to COLLECT.
- FINAL:
  - core_start_hash=1, held continuously.
  - When core_end_hash=1 && core_busy=0: digest<=core_digest and go to DONE. core_start_hash drops on that edge.
- DONE:
  - digest_valid=1; digest and len_err held stable.
  - On digest_ack: digest_valid<=0, then RST_CORE.
  - digest_ack in any other state is ignored.
- Latency: after the first byte the block's core_data_ready rises no earlier than cycle r/8. Minimum one block per core permutation.
- Rules:
  - core_data_ready and core_start_hash are never high together.
  - Empty messages are impossible: s_last always tags a byte.
- Mid-operation rst: abandons the message, then behaves exactly as the reset values above. Any partially accepted bytes are dropped.

Optional Feature:
- Macro: SPONGENT_DRV_TIMEOUT_EN.
- Defined:
  - Adds a watchdog counter cleared on each entry to SEND, WAIT_IDLE or FINAL.
  - Reaching TIMEOUT_CYCLES in any of these states forces DONE with digest=0 and a new output timeout_err=1, qualified by digest_valid.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter and no timeout_err port.
  - The driver waits indefinitely.

Decomposition:
- Package spongent_drv_pkg: state enum drv_state_t; localparams BYTES_PER_BLOCK=r/8 and its counter width. r is passed as a package function argument or kept as a module localparam.
- One sub-module: spongent_byte_packer.
  - Owns the byte shift register, count, full/last detection, zero-fill and len_err.
  - Has clear and shift-enable inputs.
- FSM stays in the top module.

Test Plan:
- r=16, bytes 0xAB,0xCD(last):
  - core_data=16'hABCD.
  - core_data_ready high until core_busy is seen, then one block sent.
  - core_start_hash follows after busy falls.
  - digest_valid rises with digest==core_digest; len_err=0.
- r=16, 5 bytes 01..05, last on 05:
  - Three blocks 0x0102, 0x0304, 0x0500.
  - len_err=1 at digest_valid.
- Back-to-back messages: digest_ack held high in DONE.
  - core_rst pulses exactly 1 cycle.
  - Second message's digest is correct, with no residue from the first.
- s_valid gaps and digest_ack delayed 50 cycles:
  - Packing is unaffected.
  - digest and digest_valid stay stable for all 50 cycles.
- rst asserted during WAIT_IDLE:
  - Next cycle: core_rst=1 and s_ready=0.
  - The following message hashes correctly.
- With SPONGENT_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=100, core_busy stuck at 1:
  - DONE after 100 cycles in WAIT_IDLE.
  - digest=0, timeout_err=1.
